// File: rtl/graphics_pkg.sv
// Shared constants, FSM state type and the pattern-to-colour mapping
// for the maze background writer.
package graphics_pkg;
    localparam int TILE_PX     = 8;
    localparam int TILE_ADDR_W = 10;
    localparam int TILE_ID_W   = 6;
    localparam int PAT_ADDR_W  = 12;
    localparam int WR_ADDR_W   = 16;
    localparam int COLOR_W     = 8;

    // RGB332 palette
    localparam logic [COLOR_W-1:0] BLK = 8'h00;
    localparam logic [COLOR_W-1:0] WHT = 8'hFF;
    localparam logic [COLOR_W-1:0] CRM = 8'hFE;
    localparam logic [COLOR_W-1:0] PNK = 8'hEF;
    localparam logic [COLOR_W-1:0] BLU = 8'h03;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_e;

    function automatic logic [COLOR_W-1:0] pat_color(input logic [1:0] pat,
                                                     input logic [COLOR_W-1:0] wall);
        case (pat)
            2'd0:    pat_color = BLK;
            2'd1:    pat_color = wall;
            2'd2:    pat_color = CRM;
            default: pat_color = PNK;
        endcase
    endfunction
endpackage

// File: rtl/graphics_maze_writer_if.sv
// Memory-side bus of the maze writer: tile-map read, pattern ROM read and
// frame-buffer write ports.
interface graphics_maze_writer_if;
    import graphics_pkg::*;

    logic [TILE_ADDR_W-1:0] tile_addr;
    logic [TILE_ID_W-1:0]   tile_id;
    logic [PAT_ADDR_W-1:0]  pat_addr;
    logic [1:0]             pat_data;
    logic                   wr_en;
    logic [WR_ADDR_W-1:0]   wr_addr;
    logic [COLOR_W-1:0]     wr_data;
    logic                   wr_bank;
    logic                   front_bank;

    modport master (
        output tile_addr, pat_addr, wr_en, wr_addr, wr_data, wr_bank, front_bank,
        input  tile_id, pat_data
    );

    modport slave (
        input  tile_addr, pat_addr, wr_en, wr_addr, wr_data, wr_bank, front_bank,
        output tile_id, pat_data
    );
endinterface

// File: rtl/graphics_maze_tile_counter.sv
// Pixel/tile scan counters: px fastest, then py, then col, then row.
// Everything wraps back to zero after the last pixel of the last tile.
module graphics_maze_tile_counter #(
    parameter int COLS = 30,
    parameter int ROWS = 33,
    parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_i,
    output logic [2:0]    px_o,
    output logic [2:0]    py_o,
    output logic [RW-1:0] row_o,
    output logic          px_last_o,
    output logic          tile_end_o,
    output logic          col_last_o,
    output logic          frame_end_o
);
    logic [2:0]    px_q, py_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          py_last, row_last;

    assign px_last_o   = (px_q == 3'd7);
    assign py_last     = (py_q == 3'd7);
    assign col_last_o  = (col_q == CW'(COLS - 1));
    assign row_last    = (row_q == RW'(ROWS - 1));
    assign tile_end_o  = px_last_o && py_last;
    assign frame_end_o = tile_end_o && col_last_o && row_last;

    assign px_o  = px_q;
    assign py_o  = py_q;
    assign row_o = row_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q  <= '0;
            py_q  <= '0;
            col_q <= '0;
            row_q <= '0;
        end else if (step_i) begin
            px_q <= px_q + 3'd1;
            if (px_last_o) begin
                py_q <= py_q + 3'd1;
                if (py_last) begin
                    col_q <= col_last_o ? '0 : col_q + CW'(1);
                    if (col_last_o)
                        row_q <= row_last ? '0 : row_q + RW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/graphics_maze_writer.sv
// Redraws the maze background tile by tile into the back buffer of a
// double-buffered, column-major frame RAM, then swaps banks.
module graphics_maze_writer
    import graphics_pkg::*;
#(
    parameter int COLS = 30,
    parameter int ROWS = 33,
    parameter int YPIX = ROWS * 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic [COLOR_W-1:0]     wall_color,
    graphics_maze_writer_if.master mem,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [WR_ADDR_W-1:0] X_STEP   = WR_ADDR_W'(YPIX);
    localparam logic [WR_ADDR_W-1:0] COL_STEP = WR_ADDR_W'(TILE_PX * YPIX);

    state_e                 state_q, state_d;
    logic                   drain_q, drain_d;
    logic                   issue;
    logic [TILE_ID_W-1:0]   tile_id_q;
    logic [TILE_ADDR_W-1:0] tile_idx_q;
    logic [WR_ADDR_W-1:0]   colbase_q, xoff_q, pix_addr, wr_addr_q;
    logic [COLOR_W-1:0]     wr_data_q, pix_color;
    logic                   wr_en_q, wr_bank_q, overrun_q;

    logic [2:0]    px, py;
    logic [RW-1:0] row;
    logic          px_last, tile_end, col_last, frame_end;

    graphics_maze_tile_counter #(.COLS(COLS), .ROWS(ROWS), .RW(RW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .step_i     (issue),
        .px_o       (px),
        .py_o       (py),
        .row_o      (row),
        .px_last_o  (px_last),
        .tile_end_o (tile_end),
        .col_last_o (col_last),
        .frame_end_o(frame_end)
    );

    // Column-major address: column base and x offset are running sums of
    // YPIX, so row*8+py is just a bit concatenation.
    assign pix_addr  = colbase_q + xoff_q + WR_ADDR_W'({row, py});
    assign pix_color = pat_color(mem.pat_data, wall_color);

    assign mem.tile_addr  = tile_idx_q;
    assign mem.pat_addr   = {tile_id_q, py, px};
    assign mem.wr_en      = wr_en_q;
    assign mem.wr_addr    = wr_addr_q;
    assign mem.wr_data    = wr_en_q ? pix_color : wr_data_q;
    assign mem.wr_bank    = wr_bank_q;
    assign mem.front_bank = ~wr_bank_q;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign overrun = overrun_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        issue   = 1'b0;
        case (state_q)
            IDLE:  if (frame_start) state_d = FETCH;
            FETCH: state_d = WAIT;
            WAIT:  state_d = DRAW;
            DRAW: begin
                // After the final pixel one more DRAW cycle lets its write
                // land before DONE, which must not carry a write.
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = DONE;
                end else begin
                    issue = 1'b1;
                    if (tile_end) begin
                        if (frame_end) drain_d = 1'b1;
                        else           state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            tile_id_q  <= '0;
            tile_idx_q <= '0;
            colbase_q  <= '0;
            xoff_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_bank_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wr_en_q <= issue;
            if (state_q == WAIT)
                tile_id_q <= mem.tile_id;
            if (issue) begin
                wr_addr_q <= pix_addr;
                xoff_q    <= px_last ? '0 : xoff_q + X_STEP;
                if (tile_end) begin
                    tile_idx_q <= frame_end ? '0 : tile_idx_q + TILE_ADDR_W'(1);
                    colbase_q  <= col_last ? '0 : colbase_q + COL_STEP;
                end
            end
            if (wr_en_q)
                wr_data_q <= pix_color;
            if (state_d == DONE)
                wr_bank_q <= ~wr_bank_q;
            if (frame_start && state_q != IDLE)
                overrun_q <= 1'b1;
        end
    end
endmodule
